ym_bus_slave: RTL

YM_BUS_SLAVE -- requirements
Module: ym_bus_slave

---
 rtl/ym_bus_slave.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ym_bus_slave.sv
// ym_bus_slave: PSG-style bus slave holding two 16 x 8 register banks (chip A/B).
// The bus mode {bdir,bc1} is synchronized (2 flops) and then glitch-filtered
// (2 cycles) before it drives the IDLE/LATCH/WRITE/READ state machine.
// A write is committed when the FSM leaves WRITE, if the latched address was valid.
//
// Optional feature macro: YM_BUS_SLAVE_RD_EN -- when defined, the READ state and
// the read data path exist; otherwise mode 01 is idle and d_oe/d_out are tied 0.
//
// Ports:
//   cpu_clock   - single clock
//   reset       - asynchronous, active-low reset
//   bdir, bc1   - bus mode from upstream decoder (00 idle, 01 read, 10 write, 11 latch)
//   ym_sel      - chip select level (0 = chip A, 1 = chip B)
//   d_in        - CPU data bus
//   d_out, d_oe - read data and its drive enable
//   wr_stb      - one-cycle pulse per committed write
//   wr_chip, wr_addr, wr_data - chip/register/masked data of last committed write
//   env_restart - one-cycle pulse on every committed write to R13
module ym_bus_slave (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       bdir,
    input  logic       bc1,
    input  logic       ym_sel,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       wr_stb,
    output logic       wr_chip,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       env_restart
);

    localparam int unsigned DW      = 8;
    localparam int unsigned AW      = 4;
    localparam int unsigned NREG    = 16;
    localparam int unsigned NCHIP   = 2;
    localparam logic [AW-1:0] ENV_REG = AW'(13);

`ifdef YM_BUS_SLAVE_RD_EN
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, LATCH = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd2, LATCH = 2'd3} state_t;
`endif

    // Clear the unimplemented upper bits of narrow registers.
    function automatic logic [DW-1:0] mask_data(input logic [AW-1:0] a, input logic [DW-1:0] d);
        case (a)
            AW'(1), AW'(3), AW'(5), AW'(13): mask_data = {4'h0, d[3:0]};
            AW'(6), AW'(8), AW'(9), AW'(10): mask_data = {3'h0, d[4:0]};
            default:                         mask_data = d;
        endcase
    endfunction

    state_t          state, state_n;
    logic            bdir_s1, bdir_s2, bc1_s1, bc1_s2;
    logic [1:0]      mode_q;
    logic [1:0]      mode_sync;
    logic            stable;
    logic [AW-1:0]   addr, addr_n;
    logic            addr_ok, addr_ok_n;
    logic            chip_q;
    logic            commit_c;

    assign mode_sync = {bdir_s2, bc1_s2};
    assign stable    = (mode_sync == mode_q);

    // Next state follows the filtered mode; LATCH updates the address every cycle.
    always_comb begin
        state_n   = state;
        addr_n    = addr;
        addr_ok_n = addr_ok;
        if (stable) begin
            case (mode_sync)
                2'b10:   state_n = WRITE;
                2'b11:   state_n = LATCH;
`ifdef YM_BUS_SLAVE_RD_EN
                2'b01:   state_n = READ;
`endif
                default: state_n = IDLE;
            endcase
        end
        if (state == LATCH) begin
            addr_n    = d_in[3:0];
            addr_ok_n = (d_in[7:4] == 4'h0);
        end
    end

    // Commit the last WRITE-cycle data on the edge that leaves WRITE.
    assign commit_c = (state == WRITE) && (state_n != WRITE) && addr_ok;

    // Synchronizer, glitch filter, FSM state and write-side outputs.
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            bdir_s1     <= 1'b0;
            bdir_s2     <= 1'b0;
            bc1_s1      <= 1'b0;
            bc1_s2      <= 1'b0;
            mode_q      <= 2'b00;
            state       <= IDLE;
            addr        <= '0;
            addr_ok     <= 1'b0;
            chip_q      <= 1'b0;
            wr_stb      <= 1'b0;
            wr_chip     <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            env_restart <= 1'b0;
        end else begin
            bdir_s1     <= bdir;
            bdir_s2     <= bdir_s1;
            bc1_s1      <= bc1;
            bc1_s2      <= bc1_s1;
            mode_q      <= mode_sync;
            state       <= state_n;
            addr        <= addr_n;
            addr_ok     <= addr_ok_n;
            wr_stb      <= commit_c;
            env_restart <= commit_c && (addr == ENV_REG);
            // Chip is frozen at WRITE entry; later ym_sel moves are ignored.
            if ((state != WRITE) && (state_n == WRITE)) begin
                chip_q <= ym_sel;
            end
            if (commit_c) begin
                wr_chip <= chip_q;
                wr_addr <= addr;
                wr_data <= mask_data(addr, d_in);
            end
        end
    end

`ifdef YM_BUS_SLAVE_RD_EN
    logic [DW-1:0] regs [NCHIP][NREG];

    // Register banks plus registered read port (chip select is live while reading).
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < int'(NCHIP); c++) begin
                for (int r = 0; r < int'(NREG); r++) begin
                    regs[c][r] <= '0;
                end
            end
            d_oe  <= 1'b0;
            d_out <= '0;
        end else begin
            if (commit_c) begin
                regs[chip_q][addr] <= mask_data(addr, d_in);
            end
            d_oe  <= (state_n == READ);
            if (state_n == READ) begin
                d_out <= addr_ok_n ? regs[ym_sel][addr_n] : 8'hFF;
            end else begin
                d_out <= '0;
            end
        end
    end
`else
    // With no read path the banks have no observer; only the write strobe
    // interface carries committed data.
    assign d_oe  = 1'b0;
    assign d_out = '0;
`endif

endmodule
